// File: rtl/ifetch_pkg.sv
// Shared definitions for the ifetch_seq program sequencer.
//   state_t     : sequencer FSM states (S_HALT is only entered when
//                 IFETCH_STACK_CHECK_EN is defined)
//   GRP_CTRL    : instruction group that carries control flow
//   OP_*        : control-flow opcodes within GRP_CTRL
//   IR_NOP      : instruction presented to the decoder when idle
//   *_MSB/_LSB  : instruction field positions
package ifetch_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [4:0]  GRP_CTRL = 5'b10000;

  localparam logic [6:0]  OP_JMP = 7'd0;
  localparam logic [6:0]  OP_JZE = 7'd1;
  localparam logic [6:0]  OP_JNE = 7'd2;
  localparam logic [6:0]  OP_JCY = 7'd3;
  localparam logic [6:0]  OP_RET = 7'd4;
  localparam logic [6:0]  OP_BSR = 7'd5;

  localparam logic [23:0] IR_NOP = 24'h080000;

  localparam int GRP_MSB = 23;
  localparam int GRP_LSB = 19;
  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 12;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 0;

endpackage

// File: rtl/ifetch_seq_ret_stack.sv
// ret_stack: return-address LIFO.
//   clk, rst : clock, synchronous active-high reset (clears pointer only)
//   push/din : write din at the current pointer, pointer++
//   pop/dout : dout is the top entry (sp-1); pop decrements the pointer
//   full     : sp == DEPTH
//   empty    : sp == 0
//   sp       : pointer, one bit wider than the index so full != empty
// Pointer and index wrap silently; overflow/underflow policing is left to
// the caller. DEPTH must be a power of 2, at least 2.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   sp
);

  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = sp[AW-1:0];
  // Popping when empty therefore reads entry DEPTH-1.
  assign rd_idx = sp[AW-1:0] - IDX_ONE;
  assign dout   = mem[rd_idx];
  assign full   = (sp == SP_FULL);
  assign empty  = (sp == '0);

  always_ff @(posedge clk) begin
    if (rst)       sp <= '0;
    else if (push) sp <= sp + SP_ONE;
    else if (pop)  sp <= sp - SP_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: program sequencer / instruction fetch ahead of the
// microinstruction decoder. Four cycles per instruction
// (FETCH, LOAD, DECODE, EXEC); EXEC stretches while hold is high.
//   clk, rst          : clock, synchronous active-high reset
//   pm_addr, pm_rd    : program memory address/read strobe (data next cycle)
//   pm_data           : program memory read data
//   IR, ir_valid      : instruction to decoder, valid only in S_DECODE
//   z_flag, cy_flag   : datapath flags, sampled on leaving S_EXEC
//   hold              : datapath busy, stalls in S_EXEC
//   pc                : current program counter
//   err               : sticky stack fault
// Optional: define IFETCH_STACK_CHECK_EN to trap BSR-on-full and
// RET-on-empty into S_HALT with err set; otherwise the stack wraps and err=0.
module ifetch_seq
  import ifetch_pkg::*;
#(
  parameter int              PC_W      = 12,
  parameter int              STK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic [23:0]     pm_data,
  output logic [23:0]     IR,
  output logic            ir_valid,
  input  logic            z_flag,
  input  logic            cy_flag,
  input  logic            hold,
  output logic [PC_W-1:0] pc,
  output logic            err
);

  localparam int SPW = $clog2(STK_DEPTH) + 1;
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state, state_nx;
  logic [23:0]     ir_q;
  logic [23:0]     ir_out;
  logic [PC_W-1:0] pc_q, pc_nx;
  logic [4:0]      grp;
  logic [6:0]      op;
  logic [PC_W-1:0] tgt;
  logic            take;
  logic            push, pop;
  logic            full, empty;
  logic [PC_W-1:0] stk_dout;
  logic [SPW-1:0]  stk_sp;

  assign grp = ir_q[GRP_MSB:GRP_LSB];
  assign op  = ir_q[OP_MSB:OP_LSB];
  assign tgt = PC_W'(ir_q[TGT_MSB:TGT_LSB]);

  assign pc       = pc_q;
  assign pm_addr  = pc_q;
  assign pm_rd    = (state == S_FETCH) && !rst;
  assign IR       = ir_out;
  assign ir_valid = (state == S_DECODE);

`ifdef IFETCH_STACK_CHECK_EN
  logic fault;
  logic err_q;
  logic unused_stk;
  assign err        = err_q;
  assign unused_stk = ^stk_sp;
`else
  logic unused_stk;
  assign err        = 1'b0;
  assign unused_stk = ^{stk_sp, full, empty};
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    take     = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
`ifdef IFETCH_STACK_CHECK_EN
    fault    = 1'b0;
`endif
    case (state)
      S_FETCH:  state_nx = S_LOAD;
      S_LOAD: begin
        state_nx = S_DECODE;
        pc_nx    = pc_q + PC_ONE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (!hold) begin
          state_nx = S_FETCH;
          if (grp == GRP_CTRL) begin
            case (op)
              OP_JMP:  take = 1'b1;
              OP_JZE:  take = z_flag;
              OP_JNE:  take = !z_flag;
              OP_JCY:  take = cy_flag;
              OP_RET:  pop  = 1'b1;
              OP_BSR:  push = 1'b1;
              default: ;
            endcase
          end
`ifdef IFETCH_STACK_CHECK_EN
          // A faulting BSR/RET leaves pc and the stack untouched.
          if ((push && full) || (pop && empty)) begin
            fault    = 1'b1;
            push     = 1'b0;
            pop      = 1'b0;
            state_nx = S_HALT;
          end
`endif
          // pc already holds the return address when BSR pushes it.
          if (take || push) pc_nx = tgt;
          else if (pop)     pc_nx = stk_dout;
        end
      end
`ifdef IFETCH_STACK_CHECK_EN
      S_HALT:   state_nx = S_HALT;
`endif
      default:  state_nx = S_FETCH;
    endcase
    // Reset aborts the instruction: no stack side effects that cycle.
    if (rst) begin
      push = 1'b0;
      pop  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc_q   <= RESET_PC;
      ir_q   <= IR_NOP;
      ir_out <= IR_NOP;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      if (state == S_LOAD) begin
        ir_q   <= pm_data;
        ir_out <= pm_data;
      end else if (state == S_DECODE) begin
        ir_out <= IR_NOP;
      end
    end
  end

`ifdef IFETCH_STACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (fault) err_q <= 1'b1;
  end
`endif

  ret_stack #(
    .DEPTH (STK_DEPTH),
    .W     (PC_W)
  ) u_stk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_q),
    .dout  (stk_dout),
    .full  (full),
    .empty (empty),
    .sp    (stk_sp)
  );

endmodule

// File: tb/tb_ifetch_seq.sv
module tb_ifetch_seq;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pm_addr, pc;
  logic        pm_rd, ir_valid, err;
  logic [23:0] pm_data = '0;
  logic [23:0] IR;
  logic        z_flag = 1'b0, cy_flag = 1'b0, hold = 1'b0;

  logic [23:0] mem [4096];

  typedef struct packed {
    logic [23:0] ir;
    logic [11:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  localparam logic [23:0] MARK = 24'h4A5A5A;

  ifetch_seq dut (
    .clk      (clk),
    .rst      (rst),
    .pm_addr  (pm_addr),
    .pm_rd    (pm_rd),
    .pm_data  (pm_data),
    .IR       (IR),
    .ir_valid (ir_valid),
    .z_flag   (z_flag),
    .cy_flag  (cy_flag),
    .hold     (hold),
    .pc       (pc),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Synchronous program memory model: one cycle read latency.
  always @(posedge clk) if (pm_rd) pm_data <= mem[pm_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: every decoder-visible instruction must match the
  // next expected {IR, pc} entry.
  always @(negedge clk) begin
    if (!rst && ir_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected (cycle %0d): got IR %h pc %h expected none", cyc, IR, pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_ir", IR, e.ir);
        chk("sb_pc", pc, e.pc);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  // Holds reset for two edges, checks reset state, then releases so that
  // the current cycle is cycle 1 (S_FETCH).
  task automatic do_reset();
    rst  = 1'b1;
    hold = 1'b0;
    repeat (2) @(negedge clk);
    cyc = 0;
    chk("rst_pm_rd", pm_rd, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", IR, IR_NOP);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_sp", dut.stk_sp, 0);
    rst = 1'b0;
    cyc = 1;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  logic [23:0] br_ins [6] = '{24'h801040, 24'h801040, 24'h802040, 24'h802040, 24'h803040, 24'h803040};
  logic        br_z   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        br_cy  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [11:0] br_pc  [6] = '{12'h040, 12'h001, 12'h001, 12'h040, 12'h040, 12'h001};

  initial begin
    // Sequential fetch: IR valid only in cycles 3, 7, 11.
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 24'h400005;
    for (int k = 1; k <= 3; k++) q.push_back('{ir: 24'h400005, pc: 12'(k)});
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step();
      chk("seq_ir", IR, (c == 3 || c == 7 || c == 11) ? 24'h400005 : IR_NOP);
    end
    chk("seq_sb_drained", q.size(), 0);

    // Unconditional jump.
    clear_mem();
    mem[0] = 24'h800123;
    mem[12'h123] = MARK;
    q.push_back('{ir: 24'h800123, pc: 12'h001});
    q.push_back('{ir: MARK,       pc: 12'h124});
    do_reset();
    run_to(5);
    chk("jmp_pm_rd", pm_rd, 1);
    chk("jmp_pm_addr", pm_addr, 12'h123);
    run_to(8);
    chk("jmp_sb_drained", q.size(), 0);

    // Conditional branches, both flag values each.
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      mem[0]  = br_ins[t];
      z_flag  = br_z[t];
      cy_flag = br_cy[t];
      q.push_back('{ir: br_ins[t], pc: 12'h001});
      do_reset();
      run_to(5);
      chk("br_pc", pc, br_pc[t]);
      chk("br_pm_addr", pm_addr, br_pc[t]);
      chk("br_sb_drained", q.size(), 0);
    end
    z_flag  = 1'b0;
    cy_flag = 1'b0;

    // Subroutine call and return.
    clear_mem();
    mem[0]       = 24'h800010;
    mem[12'h010] = 24'h805200;
    mem[12'h011] = MARK;
    mem[12'h200] = 24'h804000;
    q.push_back('{ir: 24'h800010, pc: 12'h001});
    q.push_back('{ir: 24'h805200, pc: 12'h011});
    q.push_back('{ir: 24'h804000, pc: 12'h201});
    q.push_back('{ir: MARK,       pc: 12'h012});
    do_reset();
    run_to(9);
    chk("bsr_pc", pc, 12'h200);
    chk("bsr_sp", dut.stk_sp, 1);
    run_to(13);
    chk("ret_pc", pc, 12'h011);
    chk("ret_sp", dut.stk_sp, 0);
    run_to(16);
    chk("sub_sb_drained", q.size(), 0);

    // Hold stretches S_EXEC of a JMP for 5 cycles.
    clear_mem();
    mem[0] = 24'h800123;
    mem[12'h123] = MARK;
    q.push_back('{ir: 24'h800123, pc: 12'h001});
    q.push_back('{ir: MARK,       pc: 12'h124});
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      hold = (c >= 4 && c <= 8);
      if (c >= 5 && c <= 9) begin
        chk("hold_pm_rd", pm_rd, 0);
        chk("hold_pc", pc, 12'h001);
      end
      if (c == 10) begin
        chk("hold_rel_pm_rd", pm_rd, 1);
        chk("hold_rel_pm_addr", pm_addr, 12'h123);
      end
    end
    hold = 1'b0;
    chk("hold_sb_drained", q.size(), 0);

    // Nine nested BSRs on an 8-deep stack.
    clear_mem();
    for (int k = 0; k < 9; k++) begin
      mem[k*16] = 24'h805000 | 24'((k + 1) * 16);
      q.push_back('{ir: 24'h805000 | 24'((k + 1) * 16), pc: 12'(k*16 + 1)});
    end
    mem[12'h090] = 24'h804000;
`ifdef IFETCH_STACK_CHECK_EN
    do_reset();
    run_to(37);
    chk("ovf_err", err, 1);
    chk("ovf_halt", dut.state == S_HALT, 1);
    chk("ovf_pm_rd", pm_rd, 0);
    chk("ovf_sp", dut.stk_sp, 8);
    chk("ovf_pc", pc, 12'h081);
    run_to(42);
    chk("halt_pm_rd", pm_rd, 0);
    chk("halt_ir", IR, IR_NOP);
    chk("halt_err", err, 1);
`else
    q.push_back('{ir: 24'h804000, pc: 12'h091});
    do_reset();
    run_to(37);
    chk("ovf_err", err, 0);
    chk("ovf_sp", dut.stk_sp, 9);
    chk("ovf_pc", pc, 12'h090);
    run_to(41);
    // Popping from sp=9 reads entry 0, which the ninth BSR overwrote.
    chk("ovf_ret_pc", pc, 12'h081);
    chk("ovf_ret_sp", dut.stk_sp, 8);
    chk("ovf_err_late", err, 0);
    run_to(42);
`endif
    chk("ovf_sb_drained", q.size(), 0);

    // Reset during S_EXEC of a BSR aborts it: no push, pc back to reset.
    clear_mem();
    mem[0] = 24'h805200;
    q.push_back('{ir: 24'h805200, pc: 12'h001});
    do_reset();
    run_to(4);
    do_reset();
    chk("abort_sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
